// File: rtl/sa_deskew_if.sv
// Result-lane bundle between the systolic array columns and the deskew block.
// master drives the skewed lanes; slave returns the aligned vector.
interface sa_deskew_if #(
    parameter int LANES     = 4,
    parameter int DAT_WIDTH = 16
);
    logic [LANES-1:0]           i_dat_vld;
    logic [LANES*DAT_WIDTH-1:0] i_dat;
    logic                       o_dat_vld;
    logic [LANES*DAT_WIDTH-1:0] o_dat;
    logic                       o_err;

    modport master (
        output i_dat_vld, i_dat,
        input  o_dat_vld, o_dat, o_err
    );

    modport slave (
        input  i_dat_vld, i_dat,
        output o_dat_vld, o_dat, o_err
    );
endinterface

// File: rtl/sa_deskew.sv
// Realigns diagonally skewed systolic-array result lanes into one vector.
// Lane i is delayed LANES-1-i cycles, then all lanes register together.
module sa_deskew #(
    parameter int LANES     = 4,
    parameter int DAT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    sa_deskew_if.slave  bus
);

    logic [LANES-1:0]                a_vld;
    logic [LANES-1:0][DAT_WIDTH-1:0] a_dat;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int D = LANES - 1 - i;

        logic                 in_vld;
        logic [DAT_WIDTH-1:0] in_dat;

        assign in_vld = bus.i_dat_vld[i];
        assign in_dat = bus.i_dat[i*DAT_WIDTH +: DAT_WIDTH];

        if (D == 0) begin : g_pass
            assign a_vld[i] = in_vld;
            assign a_dat[i] = in_dat;
        end else begin : g_dly
            logic [D-1:0]                vld_q;
            logic [D-1:0][DAT_WIDTH-1:0] dat_q;

            // Data only advances under a valid so idle lanes do not toggle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    dat_q <= '0;
                end else begin
                    vld_q[0] <= in_vld;
                    if (in_vld) dat_q[0] <= in_dat;
                    for (int s = 1; s < D; s++) begin
                        vld_q[s] <= vld_q[s-1];
                        if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
                    end
                end
            end

            assign a_vld[i] = vld_q[D-1];
            assign a_dat[i] = dat_q[D-1];
        end
    end

    logic                            all_v;
    logic                            any_v;
    logic                            o_vld_q, o_vld_d;
    logic [LANES-1:0][DAT_WIDTH-1:0] o_dat_q, o_dat_d;
    logic                            o_err_q, o_err_d;

    always_comb begin
        all_v   = &a_vld;
        any_v   = |a_vld;
        o_vld_d = all_v;
        o_dat_d = all_v ? a_dat : o_dat_q;
        o_err_d = o_err_q | (any_v & ~all_v);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld_q <= 1'b0;
            o_dat_q <= '0;
            o_err_q <= 1'b0;
        end else begin
            o_vld_q <= o_vld_d;
            o_dat_q <= o_dat_d;
            o_err_q <= o_err_d;
        end
    end

    assign bus.o_dat_vld = o_vld_q;
    assign bus.o_dat     = o_dat_q;
    assign bus.o_err     = o_err_q;

endmodule

// File: tb/tb_sa_deskew.sv
// Directed and random checks of sa_deskew (LANES=4 and LANES=1 instances)
// against a cycle-history reference model.
module tb_sa_deskew;

    logic clk;
    logic rst;

    sa_deskew_if #(.LANES(4), .DAT_WIDTH(16)) bus ();
    sa_deskew_if #(.LANES(1), .DAT_WIDTH(16)) bus1 ();

    sa_deskew #(.LANES(4), .DAT_WIDTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    sa_deskew #(.LANES(1), .DAT_WIDTH(16)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    logic [3:0]  sched_vld [0:1023];
    logic [63:0] sched_dat [0:1023];
    logic [3:0]  hv [0:1023];
    logic [63:0] hd [0:1023];

    logic        ev = 1'b0;
    logic [63:0] ed = '0;
    logic        ee = 1'b0;
    logic        e1v = 1'b0;
    logic [15:0] e1d = '0;
    logic        in1_v = 1'b0;
    logic [15:0] in1_d = '0;

    int          hits;
    int          first_n;
    int          last_n;
    logic [63:0] last_d;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h cyc=%0d",
                   tag, got, exp, cyc);
        end
    endtask

    // Vector lane i is presented at cycle s+i; lanes with keep=0 are dropped.
    task automatic launch(input int s, input logic [63:0] vec,
                          input logic [3:0] keep);
        for (int i = 0; i < 4; i++) begin
            if (keep[i]) begin
                sched_vld[s+i][i] = 1'b1;
                sched_dat[s+i][i*16 +: 16] = vec[i*16 +: 16];
            end
        end
    endtask

    task automatic step(input bit r);
        logic [3:0]  v;
        logic [63:0] d;
        logic [3:0]  tv;
        logic [63:0] td;
        int          n;
        int          k;
        n = cyc;
        v = sched_vld[n];
        d = sched_dat[n];
        for (int i = 0; i < 4; i++)
            if (!v[i]) d[i*16 +: 16] = 16'($urandom);
        rst = r;
        bus.i_dat_vld  = v;
        bus.i_dat      = d;
        bus1.i_dat_vld = in1_v;
        bus1.i_dat     = in1_d;
        hv[n] = v;
        hd[n] = d;
        @(posedge clk);
        #1;
        if (r) begin
            for (int j = n - 3; j <= n; j++)
                if (j >= 0) hv[j] = '0;
            ev  = 1'b0;
            ed  = '0;
            ee  = 1'b0;
            e1v = 1'b0;
            e1d = '0;
        end else begin
            tv = '0;
            td = '0;
            for (int i = 0; i < 4; i++) begin
                k = n - (3 - i);
                if (k >= 0 && hv[k][i]) begin
                    tv[i] = 1'b1;
                    td[i*16 +: 16] = hd[k][i*16 +: 16];
                end
            end
            ev = (tv == 4'hF);
            if (ev) ed = td;
            if (tv != 4'h0 && tv != 4'hF) ee = 1'b1;
            e1v = in1_v;
            if (in1_v) e1d = in1_d;
        end
        chk("vld",  64'(bus.o_dat_vld), 64'(ev));
        chk("dat",  bus.o_dat,          ed);
        chk("err",  64'(bus.o_err),     64'(ee));
        chk("vld1", 64'(bus1.o_dat_vld), 64'(e1v));
        chk("dat1", 64'(bus1.o_dat),     64'(e1d));
        chk("err1", 64'(bus1.o_err),     64'd0);
        if (bus.o_dat_vld) begin
            if (hits == 0) first_n = n;
            hits++;
            last_n = n;
            last_d = bus.o_dat;
        end
        cyc++;
    endtask

    function automatic logic [63:0] mkvec(input int k);
        logic [63:0] x;
        for (int i = 0; i < 4; i++)
            x[i*16 +: 16] = 16'(16 * k + i);
        return x;
    endfunction

    initial begin
        for (int j = 0; j < 1024; j++) begin
            sched_vld[j] = '0;
            sched_dat[j] = '0;
        end
        rst = 1'b1;
        bus.i_dat_vld  = '0;
        bus.i_dat      = '0;
        bus1.i_dat_vld = '0;
        bus1.i_dat     = '0;
        hits = 0;
        first_n = -1;
        last_n = -1;
        last_d = '0;

        // reset with random traffic
        for (int j = 0; j < 3; j++) begin
            sched_vld[j] = 4'($urandom);
            in1_v = 1'($urandom);
            in1_d = 16'($urandom);
            step(1);
            chk("rst_vld", 64'(bus.o_dat_vld), 64'd0);
            chk("rst_dat", bus.o_dat, 64'd0);
            chk("rst_err", 64'(bus.o_err), 64'd0);
        end
        in1_v = 1'b0;
        step(0);
        chk("rel_vld", 64'(bus.o_dat_vld), 64'd0);
        chk("rel_dat", bus.o_dat, 64'd0);

        // single vector launched at cycle 10
        launch(10, 64'h0103_0102_0101_0100, 4'hF);
        hits = 0;
        while (cyc < 20) step(0);
        chk("single_hits", 64'(hits), 64'd1);
        chk("single_when", 64'(first_n), 64'd13);
        chk("single_dat",  last_d, 64'h0103_0102_0101_0100);
        chk("single_err",  64'(bus.o_err), 64'd0);

        // back-to-back stream of 8
        for (int k = 0; k < 8; k++) launch(20 + k, mkvec(k), 4'hF);
        hits = 0;
        while (cyc < 36) step(0);
        chk("strm_hits",  64'(hits), 64'd8);
        chk("strm_first", 64'(first_n), 64'd23);
        chk("strm_last",  64'(last_n), 64'd30);
        chk("strm_dat",   last_d, 64'h0073_0072_0071_0070);
        chk("strm_err",   64'(bus.o_err), 64'd0);

        // stream with vector 3 missing lane 2
        for (int k = 0; k < 8; k++)
            launch(40 + k, mkvec(k), (k == 3) ? 4'b1011 : 4'hF);
        hits = 0;
        while (cyc < 46) step(0);
        chk("drop_pre_err", 64'(bus.o_err), 64'd0);
        step(0);
        chk("drop_err_set", 64'(bus.o_err), 64'd1);
        while (cyc < 56) step(0);
        chk("drop_hits", 64'(hits), 64'd7);
        chk("drop_dat",  last_d, 64'h0073_0072_0071_0070);
        chk("drop_err",  64'(bus.o_err), 64'd1);

        // reset while two vectors are in flight
        launch(60, mkvec(10), 4'b0111);
        launch(61, mkvec(11), 4'b0011);
        hits = 0;
        while (cyc < 62) step(0);
        step(1);
        chk("flush_err", 64'(bus.o_err), 64'd0);
        launch(65, 64'hCAFE_BABE_DEAD_BEEF, 4'hF);
        while (cyc < 76) step(0);
        chk("flush_hits", 64'(hits), 64'd1);
        chk("flush_when", 64'(first_n), 64'd68);
        chk("flush_dat",  last_d, 64'hCAFE_BABE_DEAD_BEEF);

        // LANES=1 instance: single register
        in1_v = 1'b1;
        in1_d = 16'hBEEF;
        step(0);
        chk("l1_vld", 64'(bus1.o_dat_vld), 64'd1);
        chk("l1_dat", 64'(bus1.o_dat), 64'h0000_0000_0000_BEEF);
        in1_v = 1'b0;
        in1_d = 16'h1234;
        step(0);
        chk("l1_vld_off", 64'(bus1.o_dat_vld), 64'd0);
        chk("l1_hold", 64'(bus1.o_dat), 64'h0000_0000_0000_BEEF);

        // random traffic with occasional drops and resets
        while (cyc < 600) begin
            if ($urandom_range(0, 3) != 0)
                launch(cyc, {$urandom, $urandom},
                       ($urandom_range(0, 15) == 0) ?
                       ~(4'b0001 << $urandom_range(0, 3)) : 4'hF);
            in1_v = 1'($urandom);
            in1_d = 16'($urandom);
            step($urandom_range(0, 63) == 0);
        end
        in1_v = 1'b0;
        while (cyc < 610) step(0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
